reorder_buffer: RTL

Circular reorder buffer (ROB) for the Tomasulo RISC-V core.
- Allocates one entry per cycle for the dispatcher.
- Captures results broadcast by the RS and LSB CDBs.
- Serves operand lookups to dispatch.
- Retires in order, one entry per cycle, writing the register file or releasing stores to the LSB.
- Detects branch mispredicts at commit and broadcasts the flush/redirect consumed by RS, LSB, dispatcher and fetch.

---
 rtl/reorder_buffer_pkg.sv | 36 +++
 rtl/reorder_buffer_branch_check.sv | 18 +
 rtl/reorder_buffer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: ROB sizing, instruction op codes and op-class helpers
package reorder_buffer_pkg;
    localparam int ROB_SIZE     = 16;
    localparam int ROB_SIZE_ARR = ROB_SIZE - 1;
    localparam int ROB_IDX_W    = 4;
    localparam int ROB_CNT_W    = ROB_IDX_W + 1;
    localparam int OPE_WIDTH    = 6;

    localparam logic [OPE_WIDTH-1:0] OP_NOP = 6'd0, OP_LUI = 6'd1, OP_AUIPC = 6'd2, OP_JAL = 6'd3,
        OP_JALR = 6'd4, OP_BEQ = 6'd5, OP_BNE = 6'd6, OP_BLT = 6'd7, OP_BGE = 6'd8, OP_BLTU = 6'd9,
        OP_BGEU = 6'd10, OP_LB = 6'd11, OP_LH = 6'd12, OP_LW = 6'd13, OP_LBU = 6'd14, OP_LHU = 6'd15,
        OP_SB = 6'd16, OP_SH = 6'd17, OP_SW = 6'd18, OP_ADDI = 6'd19, OP_SLTI = 6'd20, OP_SLTIU = 6'd21,
        OP_XORI = 6'd22, OP_ORI = 6'd23, OP_ANDI = 6'd24, OP_SLLI = 6'd25, OP_SRLI = 6'd26,
        OP_SRAI = 6'd27, OP_ADD = 6'd28, OP_SUB = 6'd29, OP_SLL = 6'd30, OP_SLT = 6'd31,
        OP_SLTU = 6'd32, OP_XOR = 6'd33, OP_SRL = 6'd34, OP_SRA = 6'd35, OP_OR = 6'd36, OP_AND = 6'd37;

    typedef struct packed {
        logic                 busy;
        logic                 ready;
        logic [OPE_WIDTH-1:0] typ;
        logic [4:0]           rd;
        logic [31:0]          pc;
        logic                 pred_jump;
        logic [31:0]          value;
        logic                 jump;
        logic [31:0]          pc_next;
    } rob_entry_t;

    function automatic logic is_branch(input logic [OPE_WIDTH-1:0] t);
        return t >= OP_BEQ && t <= OP_BGEU;
    endfunction

    function automatic logic is_store(input logic [OPE_WIDTH-1:0] t);
        return t >= OP_SB && t <= OP_SW;
    endfunction
endpackage

// File: rtl/reorder_buffer_branch_check.sv
// reorder_buffer_branch_check: resolves the retiring control-flow entry into mispredict and redirect pc
module reorder_buffer_branch_check
    import reorder_buffer_pkg::*;
(
    input  logic [OPE_WIDTH-1:0] typ,
    input  logic                 pred_jump,
    input  logic                 jump,
    input  logic [31:0]          pc,
    input  logic [31:0]          pc_next,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc
);
    // JALR targets are never predicted, so it always redirects; JAL is resolved at fetch
    always_comb begin
        mispredict  = is_branch(typ) ? (jump != pred_jump) : (typ == OP_JALR);
        redirect_pc = (is_branch(typ) && !jump) ? pc + 32'd4 : pc_next;
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular ROB with in-order retire, CDB capture, operand bypass and commit-time flush
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 alloc_valid,
    input  logic [OPE_WIDTH-1:0] alloc_type,
    input  logic [4:0]           alloc_rd,
    input  logic [31:0]          alloc_pc,
    input  logic                 alloc_pred_jump,
    output logic [ROB_IDX_W-1:0] alloc_id,
    output logic                 full_rob,
    input  logic [ROB_IDX_W-1:0] query_j_id,
    input  logic [ROB_IDX_W-1:0] query_k_id,
    output logic                 query_j_ready,
    output logic                 query_k_ready,
    output logic [31:0]          query_j_value,
    output logic [31:0]          query_k_value,
    input  logic                 cdb_rs_valid,
    input  logic [ROB_IDX_W-1:0] cdb_rs_rob_id,
    input  logic [31:0]          cdb_rs_value,
    input  logic                 cdb_rs_jump,
    input  logic [31:0]          cdb_rs_pc_next,
    input  logic                 cdb_lsb_valid,
    input  logic [ROB_IDX_W-1:0] cdb_lsb_rob_id,
    input  logic [31:0]          cdb_lsb_value,
    output logic                 commit_valid,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_value,
    output logic [ROB_IDX_W-1:0] commit_rob_id,
    output logic                 commit_store,
    output logic                 mispredict,
    output logic [31:0]          redirect_pc
);
    rob_entry_t ent [0:ROB_SIZE_ARR];
    rob_entry_t h;
    logic [ROB_IDX_W-1:0] head, tail;
    logic [ROB_CNT_W-1:0] count;
    logic do_alloc, do_commit, br_mis, flush;
    logic [31:0] br_pc;
    logic rs_j, rs_k, lsb_j, lsb_k;

    assign h         = ent[head];
    assign full_rob  = count == ROB_CNT_W'(ROB_SIZE);
    assign alloc_id  = tail;
    assign do_alloc  = alloc_valid && !full_rob;
    assign do_commit = h.busy && h.ready;
    assign flush     = do_commit && br_mis;

    // same-cycle CDB results bypass the stored value; RS wins over LSB
    assign rs_j  = cdb_rs_valid && cdb_rs_rob_id == query_j_id;
    assign rs_k  = cdb_rs_valid && cdb_rs_rob_id == query_k_id;
    assign lsb_j = cdb_lsb_valid && cdb_lsb_rob_id == query_j_id;
    assign lsb_k = cdb_lsb_valid && cdb_lsb_rob_id == query_k_id;
    assign query_j_ready = ent[query_j_id].ready || rs_j || lsb_j;
    assign query_k_ready = ent[query_k_id].ready || rs_k || lsb_k;
    assign query_j_value = rs_j ? cdb_rs_value : lsb_j ? cdb_lsb_value : ent[query_j_id].value;
    assign query_k_value = rs_k ? cdb_rs_value : lsb_k ? cdb_lsb_value : ent[query_k_id].value;

    reorder_buffer_branch_check u_branch_check (
        .typ        (h.typ),
        .pred_jump  (h.pred_jump),
        .jump       (h.jump),
        .pc         (h.pc),
        .pc_next    (h.pc_next),
        .mispredict (br_mis),
        .redirect_pc(br_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                ent[i].busy  <= 1'b0;
                ent[i].ready <= 1'b0;
            end
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            commit_valid  <= 1'b0;
            commit_store  <= 1'b0;
            commit_rd     <= '0;
            commit_value  <= '0;
            commit_rob_id <= '0;
            mispredict    <= 1'b0;
            redirect_pc   <= '0;
        end else if (!rdy) begin
            commit_valid <= 1'b0;
            commit_store <= 1'b0;
            mispredict   <= 1'b0;
            redirect_pc  <= '0;
        end else begin
            commit_valid <= do_commit && !is_branch(h.typ) && !is_store(h.typ);
            commit_store <= do_commit && is_store(h.typ);
            mispredict   <= flush;
            redirect_pc  <= flush ? br_pc : '0;
            if (do_commit) begin
                commit_rd     <= h.rd;
                commit_value  <= h.value;
                commit_rob_id <= head;
            end
            if (flush) begin
                for (int i = 0; i < ROB_SIZE; i++) begin
                    ent[i].busy  <= 1'b0;
                    ent[i].ready <= 1'b0;
                end
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_alloc)
                    ent[tail] <= '{busy: 1'b1, ready: 1'b0, typ: alloc_type, rd: alloc_rd, pc: alloc_pc,
                                   pred_jump: alloc_pred_jump, value: '0, jump: 1'b0, pc_next: '0};
                if (cdb_rs_valid) begin
                    ent[cdb_rs_rob_id].ready   <= 1'b1;
                    ent[cdb_rs_rob_id].value   <= cdb_rs_value;
                    ent[cdb_rs_rob_id].jump    <= cdb_rs_jump;
                    ent[cdb_rs_rob_id].pc_next <= cdb_rs_pc_next;
                end
                if (cdb_lsb_valid) begin
                    ent[cdb_lsb_rob_id].ready <= 1'b1;
                    ent[cdb_lsb_rob_id].value <= cdb_lsb_value;
                end
                if (do_commit) begin
                    ent[head].busy  <= 1'b0;
                    ent[head].ready <= 1'b0;
                end
                head  <= head + ROB_IDX_W'(do_commit);
                tail  <= tail + ROB_IDX_W'(do_alloc);
                count <= count + ROB_CNT_W'(do_alloc) - ROB_CNT_W'(do_commit);
            end
        end
    end
endmodule
